// File: rtl/uart_comm_master.sv
// uart_comm_master: host-side UART master that sends 16-bit commands high byte first
// and receives response bytes into rx_data with a rdy flag.
module uart_comm_master #(
    parameter int BAUD_DIV = 108
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        cmd_cmplt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  rx_data,
    output logic        rdy,
    input  logic        clr_rdy
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t     tx_state;
    logic [7:0]    lo_hold;
    logic [9:0]    tx_shift;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;

    rx_state_t     rx_state;
    logic          rx_s1, rx_s2, rx_s3;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    // tx_shift holds {stop, data, start}; bit 0 is always the bit currently on TX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= IDLE;
            lo_hold   <= '0;
            tx_shift  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            TX        <= 1'b1;
            cmd_cmplt <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: if (snd_cmd) begin
                    lo_hold   <= cmd[7:0];
                    cmd_cmplt <= 1'b0;
                    tx_shift  <= {1'b1, cmd[15:8], 1'b0};
                    TX        <= 1'b0;
                    tx_cnt    <= '0;
                    tx_bit    <= '0;
                    tx_state  <= SEND_HI;
                end
                default: if (tx_cnt != BIT_END) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end else begin
                    tx_cnt <= '0;
                    if (tx_bit != 4'd9) begin
                        tx_bit   <= tx_bit + 1'b1;
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        TX       <= tx_shift[1];
                    end else if (tx_state == SEND_HI) begin
                        tx_bit   <= '0;
                        tx_shift <= {1'b1, lo_hold, 1'b0};
                        TX       <= 1'b0;
                        tx_state <= SEND_LO;
                    end else begin
                        cmd_cmplt <= 1'b1;
                        tx_state  <= IDLE;
                    end
                end
            endcase
        end
    end

    // rdy set at the stop sample is written last so it wins over clr_rdy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (clr_rdy)
                rdy <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_s3 && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                    rdy      <= 1'b0;
                end
                RX_START: if (rx_cnt != HALF_END) begin
                    rx_cnt <= rx_cnt + 1'b1;
                end else begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt != BIT_END) begin
                    rx_cnt <= rx_cnt + 1'b1;
                end else begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7)
                        rx_state <= RX_STOP;
                end
                default: if (rx_cnt != BIT_END) begin
                    rx_cnt <= rx_cnt + 1'b1;
                end else begin
                    rx_cnt   <= '0;
                    rx_data  <= rx_shift;
                    rdy      <= 1'b1;
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_comm_master.sv
// tb_uart_comm_master: directed bench for uart_comm_master; decodes TX at mid-bits,
// drives RX frames from a bench UART and loops TX back to RX.
module tb_uart_comm_master;
    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic        clr_rdy = 1'b0;
    logic        loop = 1'b0;
    logic        bench_rx = 1'b1;
    logic [15:0] cmd = '0;
    logic        cmd_cmplt, TX, rdy, RX;
    logic [7:0]  rx_data;
    int          checks = 0;
    int          errors = 0;

    assign RX = loop ? TX : bench_rx;
    always #5 clk = ~clk;

    uart_comm_master #(.BAUD_DIV(B)) dut (
        .clk(clk),
        .rst(rst),
        .snd_cmd(snd_cmd),
        .cmd(cmd),
        .cmd_cmplt(cmd_cmplt),
        .TX(TX),
        .RX(RX),
        .rx_data(rx_data),
        .rdy(rdy),
        .clr_rdy(clr_rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 12 * B);
        check(tag, rdy, 1);
    endtask

    task automatic wait_rdy_low(input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (rdy && n < 4 * B);
        check(tag, rdy, 0);
    endtask

    task automatic clear_rdy();
        @(negedge clk) clr_rdy = 1'b1;
        @(negedge clk) clr_rdy = 1'b0;
        check("clr_rdy", rdy, 0);
    endtask

    // must be entered on a negedge so consecutive calls give gap-free frames
    task automatic uart_tx(input logic [7:0] b, input logic stop);
        bench_rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bench_rx = b[i];
            repeat (B) @(negedge clk);
        end
        bench_rx = stop;
        repeat (B) @(negedge clk);
        bench_rx = 1'b1;
    endtask

    task automatic send_cmd(input logic [15:0] c, input logic intrude, input logic [15:0] other);
        logic [19:0] f;
        int n;
        @(negedge clk);
        cmd = c;
        snd_cmd = 1'b1;
        fork
            begin
                @(negedge clk) snd_cmd = 1'b0;
                if (intrude) begin
                    repeat (3 * B) @(negedge clk);
                    cmd = other;
                    snd_cmd = 1'b1;
                    @(negedge clk) snd_cmd = 1'b0;
                end
            end
            begin
                @(posedge clk);
                n = 0;
                #1 check("cmplt_clr", cmd_cmplt, 0);
                for (int k = 0; k < 20; k++) begin
                    repeat (k == 0 ? B / 2 : B) @(posedge clk);
                    n += (k == 0 ? B / 2 : B);
                    #1 f[k] = TX;
                end
                check("tx_hi_frame", f[9:0], {1'b1, c[15:8], 1'b0});
                check("tx_lo_frame", f[19:10], {1'b1, c[7:0], 1'b0});
                while (!cmd_cmplt && n < 21 * B) begin
                    @(posedge clk);
                    n++;
                    #1;
                end
                check("cmplt_delay", n + 1, 20 * B + 1);
            end
        join
        repeat (10) @(posedge clk);
        #1 check("cmplt_hold", cmd_cmplt, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", TX, 1);
        check("rst_cmplt", cmd_cmplt, 0);
        check("rst_rdy", rdy, 0);
        check("rst_rx_data", rx_data, 8'h00);
        @(negedge clk) rst = 1'b0;
        repeat (50) @(posedge clk);
        #1 check("idle_tx", TX, 1);

        send_cmd(16'h4A1D, 1'b0, 16'h0000);
        send_cmd(16'h3C96, 1'b1, 16'hFFFF);

        loop = 1'b1;
        fork
            send_cmd(16'h0812, 1'b0, 16'h0000);
            begin
                wait_rdy("lb_rdy1");
                check("lb_byte1", rx_data, 8'h08);
                clear_rdy();
                wait_rdy("lb_rdy2");
                check("lb_byte2", rx_data, 8'h12);
            end
        join
        loop = 1'b0;

        clear_rdy();
        fork
            uart_tx(8'hA5, 1'b1);
            begin
                wait_rdy("rx_a5_rdy");
                check("rx_a5", rx_data, 8'hA5);
            end
        join

        clear_rdy();
        fork
            begin
                uart_tx(8'h55, 1'b1);
                uart_tx(8'hAA, 1'b1);
            end
            begin
                wait_rdy("b2b_rdy1");
                check("b2b_byte1", rx_data, 8'h55);
                wait_rdy_low("b2b_start_clr");
                wait_rdy("b2b_rdy2");
                check("b2b_byte2", rx_data, 8'hAA);
            end
        join

        clear_rdy();
        fork
            uart_tx(8'h3C, 1'b0);
            begin
                wait_rdy("frm_err_rdy");
                check("frm_err_data", rx_data, 8'h3C);
            end
        join

        clear_rdy();
        bench_rx = 1'b0;
        repeat (2) @(negedge clk);
        bench_rx = 1'b1;
        repeat (3 * B) @(negedge clk);
        check("glitch_rdy", rdy, 0);
        check("glitch_data", rx_data, 8'h3C);
        fork
            uart_tx(8'h5A, 1'b1);
            begin
                wait_rdy("post_glitch_rdy");
                check("post_glitch_data", rx_data, 8'h5A);
            end
        join

        @(negedge clk);
        cmd = 16'h4A1D;
        snd_cmd = 1'b1;
        @(negedge clk) snd_cmd = 1'b0;
        repeat (5 * B) @(negedge clk);
        check("pre_rst_tx", TX, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tx", TX, 1);
        check("mid_rst_cmplt", cmd_cmplt, 0);
        check("mid_rst_rdy", rdy, 0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        @(negedge clk) rst = 1'b0;
        repeat (2 * B) @(posedge clk);
        #1 check("post_rst_idle_tx", TX, 1);
        send_cmd(16'h4A1D, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_comm_master.md
Name: uart_comm_master

Overview:
- Host-side UART command master used in logic-analyzer system benches; mimics the PC host.
- Serializes a 16-bit command as two UART bytes, high byte first, on TX.
- Independently receives response bytes (e.g. 0xA5 ack, dump data) on RX and presents them with a ready flag.
- Contains its own transmitter and receiver; one clock domain (system clk, 100 MHz nominal).

Parameters:
- BAUD_DIV, 108, clocks per UART bit (100 MHz / 921600 baud); must be ≥ 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- snd_cmd  input  1  one-cycle pulse: latch cmd and start transmission
- cmd  input  16  command word; [15:8] sent first, then [7:0]
- cmd_cmplt  output  1  set when both bytes fully sent (stop bit done)
- TX  output  1  serial out to DUT RX, idles high
- RX  input  1  serial in from DUT TX, asynchronous
- rx_data  output  8  last received byte
- rdy  output  1  received byte valid
- clr_rdy  input  1  clears rdy

Behaviour:
- Reset values: TX=1, cmd_cmplt=0, rdy=0, rx_data=0x00, both FSMs idle, counters 0.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly BAUD_DIV clocks, so a frame is 10·BAUD_DIV clocks.
- Command FSM states: IDLE, SEND_HI, SEND_LO.
  - IDLE + snd_cmd: latch cmd into a holding register, clear cmd_cmplt, start the high byte, go to SEND_HI. TX goes low on the cycle after snd_cmd is sampled.
  - SEND_HI, when its stop bit completes: start the low byte immediately (no idle gap), go to SEND_LO.
  - SEND_LO, when its stop bit completes: set cmd_cmplt, go to IDLE.
  - cmd_cmplt therefore rises 20·BAUD_DIV+1 clocks after the snd_cmd cycle. It stays high until the next accepted snd_cmd.
  - snd_cmd while not in IDLE is ignored; the latched word is not altered.
  - Changes on cmd after latching have no effect.
- Receiver:
  - RX is double-flop synchronized; the synchronizer resets to 1.
  - Idle waits for a synchronized falling edge (start bit).
  - First sample is taken BAUD_DIV/2 clocks after the edge, at mid start bit; subsequent samples every BAUD_DIV clocks. Shift in 8 data bits LSB first, then sample the stop bit.
  - At the stop-bit sample: load rx_data, set rdy, return to idle and re-arm for the next start edge. Back-to-back frames must be received without loss.
  - A stop bit sampled as 0 (framing error) still loads rx_data and sets rdy; no error output.
  - If the start bit samples high at mid-bit (glitch), abort to idle without setting rdy.
- rdy handling:
  - clr_rdy clears rdy on the next clock.
  - Detection of a new start bit also clears rdy.
  - If clr_rdy coincides with a byte completion, set wins (rdy=1, new data).
  - rx_data holds its value until the next completed byte.
- TX and RX operate fully concurrently and independently.
- Reset asserted mid-operation: both FSMs abort immediately, TX returns to 1, all outputs go to reset values, and the partial frame is discarded.

Test Plan:
- Reset check: assert rst → TX=1, cmd_cmplt=0, rdy=0, rx_data=0x00; release, 50 idle clocks → TX stays 1.
- Send cmd=0x4A1D via snd_cmd pulse; bench decodes TX at mid-bits:
  - bytes 0x4A then 0x1D, stop bits =1, no gap;
  - cmd_cmplt rises exactly 20·BAUD_DIV+1 clocks after the pulse and holds.
- Loopback TX→RX, send 0x0812:
  - rdy sets after the first frame with rx_data=0x08;
  - clr_rdy pulse → rdy=0;
  - second frame → rx_data=0x12, rdy=1.
- Bench UART drives 0xA5 on RX → rdy=1, rx_data=0xA5; two back-to-back frames 0x55, 0xAA → both captured in order.
- snd_cmd pulsed again mid-transmission with a different cmd → ignored; TX sequence and latched word unchanged; cmd_cmplt timing unchanged.
- Assert rst halfway through the high byte → TX=1 within one clock; a subsequent snd_cmd transmits correctly from the start.
